// File: rtl/piso_sched.sv
// ============================================================================
// piso_sched : two-requester round-robin loader/framer for a shared PISO
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module piso_sched #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             latch,
    output logic [WIDTH-1:0] pdata,
    output logic             frame,
    output logic             grant,
    output logic             done
);

    localparam int C_CLOG_W = $clog2(WIDTH);
    localparam int C_CNT_W  = (C_CLOG_W > 4) ? C_CLOG_W : 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               latch_q, latch_d;
    logic               frame_q, frame_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   pdata_q, pdata_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;

    logic               w_winner;
    logic               w_accept;

    // Ready is gated by rst so nothing looks accepted while reset is held.
    always_comb begin
        w_winner   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = rst & (state_q == ST_IDLE) & req0_valid & ~w_winner;
        req1_ready = rst & (state_q == ST_IDLE) & req1_valid &  w_winner;
        w_accept   = req0_ready | req1_ready;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch_d      = 1'b0;
        frame_d      = 1'b0;
        done_d       = 1'b0;
        pdata_d      = pdata_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    pdata_d      = w_winner ? req1_data : req0_data;
                    grant_d      = w_winner;
                    last_grant_d = w_winner;
                    latch_d      = 1'b1;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                frame_d = 1'b1;
                cnt_d   = C_CNT_W'(WIDTH - 1);
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (GAP > 0) begin
                        cnt_d   = C_CNT_W'(GAP - 1);
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    frame_d = 1'b1;
                    cnt_d   = cnt_q - C_CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            latch_q      <= 1'b0;
            frame_q      <= 1'b0;
            done_q       <= 1'b0;
            pdata_q      <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            frame_q      <= frame_d;
            done_q       <= done_d;
            pdata_q      <= pdata_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign latch = latch_q;
    assign frame = frame_q;
    assign done  = done_q;
    assign pdata = pdata_q;
    assign grant = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_sched.sv
// ============================================================================
// tb_piso_sched : directed scoreboard bench for piso_sched (GAP=1 and GAP=0)
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_piso_sched;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, r0v, r1v;
    logic [7:0] r0d, r1d;
    logic       req0_ready, req1_ready, latch, frame, grant, done;
    logic [7:0] pdata;

    logic       rst_b, b_r0v, b_r1v;
    logic [7:0] b_r0d, b_r1d;
    logic       b_req0_ready, b_req1_ready, b_latch, b_frame, b_grant, b_done;
    logic [7:0] b_pdata;

    piso_sched #(.WIDTH(8), .GAP(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req1_valid(r1v), .req0_data(r0d), .req1_data(r1d),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .latch(latch), .pdata(pdata), .frame(frame), .grant(grant), .done(done)
    );

    piso_sched #(.WIDTH(8), .GAP(0)) dut_b (
        .clk(clk), .rst(rst_b),
        .req0_valid(b_r0v), .req1_valid(b_r1v), .req0_data(b_r0d), .req1_data(b_r1d),
        .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
        .latch(b_latch), .pdata(b_pdata), .frame(b_frame), .grant(b_grant), .done(b_done)
    );

    typedef struct packed {
        logic       g;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_b_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ready(input bit which, input int lim);
        int n = 0;
        while (!(which ? (b_req0_ready | b_req1_ready) : (req0_ready | req1_ready)) && n < lim) begin
            tick();
            n++;
        end
        chk(which ? "b_ready_timeout" : "ready_timeout",
            which ? (b_req0_ready | b_req1_ready) : (req0_ready | req1_ready), 1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_latch"}, latch, 1);
        chk({tag, "_no_frame_with_latch"}, frame, 0);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pdata"}, pdata, e.d);
            chk({tag, "_grant"}, grant, e.g);
        end
    endtask

    task automatic pop_check_b(input string tag);
        exp_t e;
        chk({tag, "_latch"}, b_latch, 1);
        chk({tag, "_no_frame_with_latch"}, b_frame, 0);
        if (exp_b_q.size() == 0) begin
            chk({tag, "_sb_empty"}, exp_b_q.size(), 1);
        end else begin
            e = exp_b_q.pop_front();
            chk({tag, "_pdata"}, b_pdata, e.d);
            chk({tag, "_grant"}, b_grant, e.g);
        end
    endtask

    initial begin
        int   last_acc;
        int   cnt;
        logic g;

        rst = 1'b0; r0v = 1'b0; r1v = 1'b0; r0d = 8'h00; r1d = 8'h00;
        rst_b = 1'b0; b_r0v = 1'b0; b_r1v = 1'b0; b_r0d = 8'h00; b_r1d = 8'h00;
        last_acc = 0;

        // Single requester frame, with valid offered during reset
        #2;
        r0v = 1'b1; r0d = 8'hAA;
        tick(); tick();
        chk("rst_latch", latch, 0);
        chk("rst_frame", frame, 0);
        chk("rst_done", done, 0);
        chk("rst_pdata", pdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_ready0_c0", req0_ready, 1);
        chk("t1_ready1_c0", req1_ready, 0);
        exp_q.push_back(exp_t'{1'b0, 8'hAA});
        tick();
        r0v = 1'b0;
        pop_check("t1_c1");
        for (int c = 2; c <= 9; c++) begin
            tick();
            chk("t1_frame", frame, 1);
            chk("t1_latch_low", latch, 0);
            chk("t1_done_low", done, 0);
        end
        tick();
        chk("t1_frame_c10", frame, 0);
        chk("t1_done_c10", done, 1);
        chk("t1_grant_c10", grant, 0);
        tick();
        chk("t1_done_c11", done, 0);
        r0v = 1'b1;
        #1;
        chk("t1_idle_c11", req0_ready, 1);
        r0v = 1'b0;

        // Continuous contention from reset: 0,1,0,1
        rst = 1'b0;
        #1;
        chk("t2_async_rst_pdata", pdata, 0);
        @(negedge clk);
        r0v = 1'b1; r0d = 8'h55; r1v = 1'b1; r1d = 8'hC3;
        rst = 1'b1;
        #1;
        for (int n = 0; n < 4; n++) begin
            wait_ready(1'b0, 30);
            g = n[0];
            chk("t2_ready0", req0_ready, !g);
            chk("t2_ready1", req1_ready, g);
            if (n > 0) chk("t2_period", cyc - last_acc, 11);
            last_acc = cyc;
            exp_q.push_back(exp_t'{g, g ? 8'hC3 : 8'h55});
            tick();
            pop_check("t2");
            tick();
        end
        r0v = 1'b0; r1v = 1'b0;

        // req1 raised mid-frame must wait for IDLE
        r0d = 8'h11; r0v = 1'b1;
        wait_ready(1'b0, 30);
        chk("t3_ready0", req0_ready, 1);
        exp_q.push_back(exp_t'{1'b0, 8'h11});
        tick();
        r0v = 1'b0; r0d = 8'hEE;
        pop_check("t3_a");
        tick(); tick(); tick();
        r1v = 1'b1; r1d = 8'h3C;
        #1;
        chk("t3_ready1_c4", req1_ready, 0);
        for (int c = 5; c <= 10; c++) begin
            tick();
            chk("t3_ready1_wait", req1_ready, 0);
            if (c == 5) chk("t3_pdata_stable", pdata, 8'h11);
        end
        tick();
        chk("t3_ready1_c11", req1_ready, 1);
        exp_q.push_back(exp_t'{1'b1, 8'h3C});
        tick();
        r1v = 1'b0;
        pop_check("t3_b");
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            cnt += int'(latch);
        end
        chk("t3_single_latch", cnt, 0);

        // Reset mid-frame aborts without done; req1 accepted right after release
        r0d = 8'h77; r0v = 1'b1;
        #1;
        chk("t4_ready0", req0_ready, 1);
        exp_q.push_back(exp_t'{1'b0, 8'h77});
        tick();
        r0v = 1'b0;
        pop_check("t4_a");
        for (int c = 2; c <= 5; c++) tick();
        r1v = 1'b1; r1d = 8'h42;
        rst = 1'b0;
        #1;
        chk("t4_rst_frame", frame, 0);
        chk("t4_rst_latch", latch, 0);
        chk("t4_rst_done", done, 0);
        chk("t4_rst_pdata", pdata, 0);
        chk("t4_rst_ready0", req0_ready, 0);
        chk("t4_rst_ready1", req1_ready, 0);
        tick();
        chk("t4_rst_held_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t4_ready1_first", req1_ready, 1);
        chk("t4_done_after", done, 0);
        exp_q.push_back(exp_t'{1'b1, 8'h42});
        tick();
        r1v = 1'b0;
        pop_check("t4_b");
        for (int c = 2; c <= 9; c++) begin
            tick();
            chk("t4_done_low", done, 0);
        end
        tick();
        chk("t4_done_c10", done, 1);
        tick();

        // req1 pulse entirely outside IDLE leaves no trace
        r0d = 8'h99; r0v = 1'b1;
        #1;
        chk("t5_ready0", req0_ready, 1);
        exp_q.push_back(exp_t'{1'b0, 8'h99});
        tick();
        r0v = 1'b0;
        pop_check("t5");
        tick(); tick();
        r1v = 1'b1; r1d = 8'h24;
        for (int c = 3; c <= 6; c++) begin
            #1;
            chk("t5_ready1_pulse", req1_ready, 0);
            if (c < 6) tick();
        end
        r1v = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cnt += int'(latch);
            chk("t5_ready1_none", req1_ready, 0);
            chk("t5_grant_kept", grant, 0);
        end
        chk("t5_no_latch", cnt, 0);

        // GAP=0 instance under continuous demand
        b_r0v = 1'b1; b_r0d = 8'h5A;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) begin
            wait_ready(1'b1, 30);
            chk("t6_ready0", b_req0_ready, 1);
            if (n > 0) begin
                chk("t6_period", cyc - last_acc, 10);
                chk("t6_done_at_accept", b_done, 1);
            end
            last_acc = cyc;
            exp_b_q.push_back(exp_t'{1'b0, 8'h5A});
            tick();
            pop_check_b("t6");
            cnt = int'(!b_frame);
            for (int i = 0; i < 9; i++) begin
                tick();
                cnt += int'(!b_frame);
            end
            chk("t6_frame_low_cycles", cnt, 2);
        end
        b_r0v = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/piso_sched.md
PISO_SCHED -- requirements
Module: piso_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8: word width of the shared PISO register; legal range 2..32.
REQ-002 SHALL have parameter GAP, default 1: idle cycles inserted after each frame; legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1  requester k offers a word.
REQ-006 SHALL have ports req0_data, req1_data  input  WIDTH  requester k parallel word.
REQ-007 SHALL have ports req0_ready, req1_ready  output  1  requester k word accepted this cycle when valid&ready.
REQ-008 SHALL have port latch  output  1  one-cycle load strobe to the PISO latch input.
REQ-009 SHALL have port pdata  output  WIDTH  registered word driven to the PISO din input.
REQ-010 SHALL have port frame  output  1  high exactly while the PISO dout carries frame bits.
REQ-011 SHALL have port grant  output  1  index of requester owning the current/last frame.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-013 SHALL implement states IDLE, LOAD, SHIFT, GAP.
REQ-014 SHALL, in IDLE, assert ready combinationally for exactly one requester (the arbitration winner) and no ready in any other state.
REQ-015 SHALL arbitrate round-robin: single valid wins; both valid -> requester not equal to last_grant wins; no valid -> neither ready asserted.
REQ-016 SHALL, on the edge where valid&ready, capture winner's data into pdata, update grant and last_grant, and move IDLE->LOAD.
REQ-017 SHALL keep pdata stable from capture until the next accepted word.
REQ-018 SHALL assert latch for exactly the one LOAD cycle, then move LOAD->SHIFT.
REQ-019 SHALL hold SHIFT for exactly WIDTH cycles with frame=1, using a down-counter loaded with WIDTH-1 and exiting at 0.
REQ-020 SHALL exit SHIFT to GAP if GAP>0, else directly to IDLE.
REQ-021 SHALL assert done (registered) for one cycle, in the cycle immediately after the last frame cycle, whether that cycle is GAP or IDLE.
REQ-022 SHALL hold GAP for exactly GAP cycles, then return to IDLE.
REQ-023 SHALL give frame period 1+1+WIDTH+GAP cycles under continuous demand (11 for defaults).
REQ-024 SHALL ignore valid and data changes outside IDLE; an unaccepted word is neither lost nor duplicated, and a valid deasserted before acceptance causes no transfer.
REQ-025 SHALL never assert latch and frame in the same cycle.

Reset
REQ-026 SHALL, while rst=0, force state IDLE, counter 0, latch=0, frame=0, done=0, pdata=0, grant=0, both ready=0, last_grant=1 (req0 wins first contention).
REQ-027 SHALL apply reset asynchronously, aborting any frame mid-SHIFT or mid-GAP without a done pulse.
REQ-028 SHALL be able to accept a word on the first rising edge after rst returns high.

Verification (WIDTH=8, GAP=1 unless stated; cycle 0 = acceptance cycle)
REQ-029 SHALL cover: req0 valid 0xAA alone -> req0_ready=1 cycle 0, latch=1 cycle 1 with pdata=0xAA, frame=1 cycles 2-9, done=1 cycle 10, grant=0, IDLE cycle 11.
REQ-030 SHALL cover: req0=0x55 and req1=0xC3 valid continuously -> grants 0,1,0,1; pdata 0x55,0xC3 alternating; latch pulses 11 cycles apart.
REQ-031 SHALL cover: req1 valid 0x3C raised at cycle 4 of a req0 frame -> req1_ready stays 0 until IDLE cycle 11, then accepted; exactly one latch with pdata=0x3C.
REQ-032 SHALL cover: GAP=0, req0 continuous -> done coincides with next IDLE/accept cycle; latch pulses 10 cycles apart; frame low for exactly 2 cycles between frames.
REQ-033 SHALL cover: rst driven low at cycle 5 of a frame -> frame, latch, done, pdata, both ready go 0 immediately; no done pulse; after release, req1 valid alone is accepted on the first edge.
REQ-034 SHALL cover: req1 valid asserted then dropped before an IDLE cycle -> no ready, no latch, grant unchanged.
